// File: rtl/lc3_controller.sv
// LC3 control unit: Moore FSM sequencing fetch, decode and multi-cycle execute.
// Optional TRAP execution is built when LC3_TRAP_EN is defined; otherwise TRAP halts.
module lc3_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    output logic [1:0]  aluControl,
    output logic        enaALU,
    output logic        enaMARM,
    output logic        enaPC,
    output logic        enaMDR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR,
    output logic        regWE,
    output logic        memWE,
    output logic        flagWE,
    output logic [1:0]  selPC,
    output logic        selMAR,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        selMDR,
    output logic        ldPC,
    output logic        ldIR,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        halted
);

    typedef enum logic [4:0] {
        S_F0, S_F1, S_F2, S_DEC, S_ALU, S_BR, S_JMP, S_JSR, S_LEA,
        S_MA, S_RD, S_IND, S_RD2, S_WB, S_SV, S_WR,
        S_T0, S_T1, S_T2, S_T3, S_HALT
    } state_t;

    state_t state_q, state_d;
    logic [3:0] op;

    assign op = IR[15:12];

    // State register with synchronous reset back to fetch
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_F0;
        else       state_q <= state_d;
    end

    // Next-state and control outputs; reset suppresses every load and write
    always_comb begin
        state_d    = state_q;
        aluControl = 2'b00;
        enaALU     = 1'b0;
        enaMARM    = 1'b0;
        enaPC      = 1'b0;
        enaMDR     = 1'b0;
        SR1        = IR[8:6];
        SR2        = IR[2:0];
        DR         = IR[11:9];
        regWE      = 1'b0;
        memWE      = 1'b0;
        flagWE     = 1'b0;
        selPC      = 2'b00;
        selMAR     = 1'b0;
        selEAB1    = 1'b0;
        selEAB2    = 2'b00;
        selMDR     = 1'b0;
        ldPC       = 1'b0;
        ldIR       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_F0: begin
                enaPC = 1'b1; ldMAR = 1'b1; ldPC = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                ldMDR = 1'b1; selMDR = 1'b1;
                state_d = S_F2;
            end
            S_F2: begin
                enaMDR = 1'b1; ldIR = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                case (op)
                    4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
                    4'b0000: state_d = S_BR;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_JSR;
                    4'b1110: state_d = S_LEA;
                    4'b0010, 4'b0110, 4'b1010,
                    4'b0011, 4'b0111, 4'b1011: state_d = S_MA;
`ifdef LC3_TRAP_EN
                    4'b1111: state_d = S_T0;
`endif
                    default: state_d = S_HALT;
                endcase
            end
            S_ALU: begin
                enaALU = 1'b1; regWE = 1'b1; flagWE = 1'b1;
                case (op)
                    4'b0101: aluControl = 2'b01;
                    4'b1001: aluControl = 2'b10;
                    default: aluControl = 2'b00;
                endcase
                state_d = S_F0;
            end
            S_BR: begin
                ldPC = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
                selPC = 2'b01; selEAB2 = 2'b10;
                state_d = S_F0;
            end
            S_JMP: begin
                ldPC = 1'b1; selPC = 2'b01; selEAB1 = 1'b1;
                state_d = S_F0;
            end
            S_JSR: begin
                enaPC = 1'b1; DR = 3'd7; regWE = 1'b1;
                ldPC = 1'b1; selPC = 2'b01;
                selEAB1 = ~IR[11];
                selEAB2 = IR[11] ? 2'b11 : 2'b00;
                state_d = S_F0;
            end
            S_LEA: begin
                enaMARM = 1'b1; selEAB2 = 2'b10;
                regWE = 1'b1; flagWE = 1'b1;
                state_d = S_F0;
            end
            S_MA: begin
                enaMARM = 1'b1; ldMAR = 1'b1;
                // LDR/STR are base+offset6, the rest PC+offset9
                if (op == 4'b0110 || op == 4'b0111) begin
                    selEAB1 = 1'b1; selEAB2 = 2'b01;
                end else begin
                    selEAB2 = 2'b10;
                end
                if (op == 4'b0011 || op == 4'b0111) state_d = S_SV;
                else                                 state_d = S_RD;
            end
            S_RD: begin
                ldMDR = 1'b1; selMDR = 1'b1;
                if (op == 4'b1010 || op == 4'b1011) state_d = S_IND;
                else                                 state_d = S_WB;
            end
            S_IND: begin
                enaMDR = 1'b1; ldMAR = 1'b1;
                state_d = (op == 4'b1011) ? S_SV : S_RD2;
            end
            S_RD2: begin
                ldMDR = 1'b1; selMDR = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                enaMDR = 1'b1; regWE = 1'b1; flagWE = 1'b1;
                state_d = S_F0;
            end
            S_SV: begin
                SR1 = IR[11:9]; enaALU = 1'b1; aluControl = 2'b11;
                ldMDR = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                memWE = 1'b1;
                state_d = S_F0;
            end
            S_T0: begin
                enaPC = 1'b1; DR = 3'd7; regWE = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                enaMARM = 1'b1; selMAR = 1'b1; ldMAR = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                ldMDR = 1'b1; selMDR = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                enaMDR = 1'b1; selPC = 2'b10; ldPC = 1'b1;
                state_d = S_F0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_F0;
        endcase
        if (reset) begin
            ldPC   = 1'b0;
            ldIR   = 1'b0;
            ldMAR  = 1'b0;
            ldMDR  = 1'b0;
            regWE  = 1'b0;
            memWE  = 1'b0;
            flagWE = 1'b0;
            halted = 1'b0;
        end
    end

endmodule

// File: doc/lc3_controller.md
# lc3_controller

Control unit for the LC3 processor: a Moore state machine that reads the instruction register and NZP flags back from the LC3 datapath and drives every datapath control input (bus enables, register and memory write enables, mux selects and register loads). Together with the datapath it forms the complete LC3. It sequences fetch, decode and multi-cycle execute, and guarantees at most one bus driver per cycle.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- IR  in  16  instruction register from datapath
- N, Z, P  in  1 each  condition flags from datapath
- aluControl  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
- enaALU, enaMARM, enaPC, enaMDR  out  1 each  bus tri-state enables
- SR1, SR2, DR  out  3 each  register file addresses
- regWE, memWE, flagWE  out  1 each  write enables
- selPC  out  2  00 PC+1, 01 EAB, 10 bus
- selMAR  out  1  0 EAB, 1 zext(IR[7:0])
- selEAB1  out  1  0 PC, 1 Ra
- selEAB2  out  2  00 zero, 01 sext off6, 10 sext off9, 11 sext off11
- selMDR  out  1  0 bus, 1 memory read
- ldPC, ldIR, ldMAR, ldMDR  out  1 each  register loads
- halted  out  1  high while in HALT

## Operation
- Default outputs: all enables, write enables, loads, and selects 0, except that SR1=IR[8:6], SR2=IR[2:0], DR=IR[11:9]. Each state overrides only what it lists.
- Memory model: ldMDR with selMDR=1 captures mem[MAR] at the edge. memWE writes MDR to mem[MAR] at the edge.
- Fetch and decode:
  - FETCH0: enaPC, ldMAR, ldPC (selPC=00).
  - FETCH1: ldMDR, selMDR=1.
  - FETCH2: enaMDR, ldIR.
  - DECODE: no controls asserted; branches on IR[15:12].
- ADD/AND/NOT (0001/0101/1001): EXEC asserts enaALU, regWE, flagWE, and aluControl=00/01/10 respectively.
- BR (0000): ldPC=(IR[11]&N)|(IR[10]&Z)|(IR[9]&P), with selPC=01, selEAB1=0, selEAB2=10. This is the only Mealy output.
- JMP (1100): ldPC, selPC=01, selEAB1=1, selEAB2=00.
- JSR/JSRR (0100): single state asserting enaPC, DR=7, regWE, ldPC, selPC=01.
  - IR[11]=1: selEAB1=0, selEAB2=11.
  - IR[11]=0: selEAB1=1, selEAB2=00.
  - The Ra read uses the pre-edge R7, so JSRR R7 is correct.
- LEA (1110): enaMARM, selMAR=0, selEAB1=0, selEAB2=10, regWE, flagWE.
- Address state MA: enaMARM, selMAR=0, ldMAR. Uses selEAB1=0, selEAB2=10 for PC-relative, or selEAB1=1, selEAB2=01 for LDR/STR.
- Loads:
  - LD (0010) and LDR (0110): MA → RD (ldMDR, selMDR=1) → WB (enaMDR, regWE, flagWE).
  - LDI (1010): MA → RD → IND (enaMDR, ldMAR) → RD2 → WB.
- Stores (SR1=IR[11:9] in the SV state):
  - ST (0011) and STR (0111): MA → SV (enaALU, aluControl=11, ldMDR, selMDR=0) → WR (memWE).
  - STI (1011): MA → RD → IND → SV → WR.
- TRAP (1111): see Configuration.
- Illegal/unsupported opcodes: RTI (1000) and reserved (1101) go to HALT.
- HALT: all controls 0, halted=1; the state is held until reset.
- Every execute path returns to FETCH0.
- Bus rule: at most one of enaALU/enaMARM/enaPC/enaMDR is high in any state.

## Timing
- Reset (synchronous): next state FETCH0, halted=0.
  - While reset is high, all loads and write enables (ldPC, ldIR, ldMAR, ldMDR, regWE, memWE, flagWE) are forced to 0.
  - Reset asserted mid-instruction aborts it; no write occurs in the reset cycle.
- Cycles per instruction, including 3 fetch + 1 decode:
  - 5: ADD/AND/NOT/BR/JMP/JSR/LEA
  - 7: LD/LDR/ST/STR
  - 8: TRAP
  - 9: LDI/STI
- Taken and untaken BR both take 5 cycles.
- IR, N, Z, P are sampled combinationally; they are stable, being registered in the datapath.

## Configuration
- LC3_TRAP_EN defined: TRAP executes four states:
  - T0: enaPC, DR=7, regWE.
  - T1: enaMARM, selMAR=1, ldMAR.
  - T2: ldMDR, selMDR=1.
  - T3: enaMDR, selPC=10, ldPC.
- LC3_TRAP_EN undefined: TRAP goes DECODE → HALT; R7 and PC are unchanged.

## Test plan
- Reset held 2 cycles, then released:
  - cycle 1: enaPC=ldMAR=ldPC=1, selPC=00.
  - cycle 2: ldMDR=1, selMDR=1.
  - cycle 3: enaMDR=ldIR=1.
  - During reset: all loads/WEs 0.
- IR=0x1283 (ADD R1,R2,R3): in EXEC, aluControl=00, enaALU=regWE=flagWE=1, DR=1, SR1=2, SR2=3; FETCH0 on the next cycle.
- IR=0x0405 (BRz): with Z=1, ldPC=1, selPC=01, selEAB2=10; with N=1, Z=0, ldPC=0; both take 5 cycles.
- IR=0xA602 (LDI R3):
  - exec sequence ldMAR, ldMDR, (enaMDR+ldMAR), ldMDR, then (enaMDR+regWE+flagWE, DR=3).
  - 9 cycles total; memWE never high.
- IR=0xF025 (TRAP x25):
  - with LC3_TRAP_EN: T0 DR=7 regWE; T1 selMAR=1 ldMAR; T3 selPC=10 ldPC.
  - without LC3_TRAP_EN: halted=1 from cycle 5, all loads 0 for 10+ cycles, cleared by reset.
- IR=0xB602 (STI), reset asserted in the IND state: the next state is FETCH0; memWE is never asserted.
